// File: rtl/fingerprint_match_scheduler.sv
// Captures one signal, replays it as framed streams to a bank of matched filters,
// then picks the lowest filter score and flags it against a latched threshold.
module fingerprint_match_scheduler #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int MATCH_SCORE_WIDTH = 32,
    parameter int CAPTURE_LENGTH    = 1000,
    parameter int NUM_FILTERS       = 4,
    parameter int MAX_FRAMES        = 2*CAPTURE_LENGTH+8,
    localparam int ID_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   in_valid,
    input  logic [SAMPLE_DATA_WIDTH-1:0]           in_data,
    output logic                                   in_ready,
    input  logic [MATCH_SCORE_WIDTH-1:0]           threshold,
    output logic                                   filt_rst,
    output logic                                   out_valid,
    output logic [SAMPLE_DATA_WIDTH-1:0]           out_data,
    input  logic [NUM_FILTERS-1:0]                 filt_valid,
    input  logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] filt_score,
    output logic                                   busy,
    output logic                                   result_valid,
    output logic [ID_W-1:0]                        result_id,
    output logic [MATCH_SCORE_WIDTH-1:0]           result_score,
    output logic                                   result_match,
    output logic                                   result_timeout
);
    localparam int ADDR_W  = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
    localparam int FRAME_W = $clog2(MAX_FRAMES + 1);
    localparam int IDX_W   = $clog2(NUM_FILTERS + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY, DECIDE} state_t;
    state_t state, state_nxt;

    logic [SAMPLE_DATA_WIDTH-1:0] mem [CAPTURE_LENGTH];
    logic [ADDR_W-1:0]            wr_addr, rd_addr;
    logic                         rd_gap;
    logic [FRAME_W-1:0]           frame_cnt;
    logic [NUM_FILTERS-1:0]       done_mask;
    logic [MATCH_SCORE_WIDTH-1:0] score_q [NUM_FILTERS];
    logic [MATCH_SCORE_WIDTH-1:0] thr_q;
    logic [SAMPLE_DATA_WIDTH-1:0] rd_data_p1;
    logic                         vld_p1;
    logic [IDX_W-1:0]             dec_idx;
    logic                         best_found, timeout_q;
    logic [MATCH_SCORE_WIDTH-1:0] best_score;
    logic [ID_W-1:0]              best_id;

    logic wr_en, last_wr, issue, all_done_nxt, frame_limit, last_idx, dec_end;
    logic sel_done, take, cand_found;
    logic [MATCH_SCORE_WIDTH-1:0] sel_score, cand_score;
    logic [ID_W-1:0]              cand_id;

    assign wr_en        = (state == CAPTURE) && in_valid;
    assign last_wr      = wr_en && (wr_addr == ADDR_W'(CAPTURE_LENGTH-1));
    assign issue        = (state == REPLAY) && !rd_gap;
    assign all_done_nxt = &(done_mask | filt_valid);
    // Budget expires on the gap that would complete frame MAX_FRAMES.
    assign frame_limit  = (state == REPLAY) && rd_gap && (frame_cnt == FRAME_W'(MAX_FRAMES-1));
    assign last_idx     = (dec_idx == IDX_W'(NUM_FILTERS-1));
    assign dec_end      = (dec_idx == IDX_W'(NUM_FILTERS));

    always_comb begin
        sel_score = '0;
        sel_done  = 1'b0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (dec_idx == IDX_W'(i)) begin
                sel_score = score_q[i];
                sel_done  = done_mask[i];
            end
        end
        // Strict compare keeps the lowest index on ties.
        take       = sel_done && (!best_found || (sel_score < best_score));
        cand_score = take ? sel_score : best_score;
        cand_id    = take ? ID_W'(dec_idx) : best_id;
        cand_found = best_found || take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: if (last_wr) state_nxt = REPLAY;
            REPLAY:  if (all_done_nxt || frame_limit) state_nxt = DECIDE;
            DECIDE:  if (dec_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        in_ready = (state == CAPTURE);
        busy     = (state != IDLE);
        filt_rst = (state != REPLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr        <= '0;
            rd_addr        <= '0;
            rd_gap         <= 1'b0;
            frame_cnt      <= '0;
            done_mask      <= '0;
            vld_p1         <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            dec_idx        <= '0;
            best_found     <= 1'b0;
            best_score     <= '1;
            best_id        <= '0;
            timeout_q      <= 1'b0;
            result_valid   <= 1'b0;
            result_id      <= '0;
            result_score   <= '0;
            result_match   <= 1'b0;
            result_timeout <= 1'b0;
        end else begin
            // p0 -> p1: address issue; p1 -> p2: RAM data presented to the filters
            vld_p1       <= issue && !abort;
            out_valid    <= vld_p1 && !abort;
            if (vld_p1) out_data <= rd_data_p1;
            result_valid <= 1'b0;
            case (state)
                IDLE: if (start) wr_addr <= '0;
                CAPTURE: if (wr_en) begin
                    wr_addr <= wr_addr + 1'b1;
                    if (last_wr) begin
                        rd_addr   <= '0;
                        rd_gap    <= 1'b0;
                        frame_cnt <= '0;
                        done_mask <= '0;
                    end
                end
                REPLAY: begin
                    done_mask <= done_mask | filt_valid;
                    if (rd_gap) begin
                        rd_gap    <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else if (rd_addr == ADDR_W'(CAPTURE_LENGTH-1)) begin
                        rd_addr <= '0;
                        rd_gap  <= 1'b1;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                    dec_idx    <= '0;
                    best_found <= 1'b0;
                    best_score <= '1;
                    best_id    <= '0;
                    timeout_q  <= frame_limit && !all_done_nxt;
                end
                DECIDE: if (!dec_end) begin
                    dec_idx    <= dec_idx + 1'b1;
                    best_found <= cand_found;
                    best_score <= cand_score;
                    best_id    <= cand_id;
                    if (last_idx && !abort) begin
                        result_valid   <= 1'b1;
                        result_id      <= cand_id;
                        result_score   <= cand_score;
                        result_match   <= cand_found && (cand_score <= thr_q);
                        result_timeout <= timeout_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= in_data;
        if (issue) rd_data_p1 <= mem[rd_addr];
        if ((state == IDLE) && start) thr_q <= threshold;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (last_wr)
                score_q[i] <= '0;
            else if ((state == REPLAY) && filt_valid[i] && !done_mask[i])
                score_q[i] <= filt_score[i*MATCH_SCORE_WIDTH +: MATCH_SCORE_WIDTH];
        end
    end
endmodule

// File: tb/tb_fingerprint_match_scheduler.sv
// Directed bench: capture/replay framing, score selection, duplicates, timeout,
// abort and asynchronous reset for a 4-sample, 3-filter, 5-frame configuration.
module tb_fingerprint_match_scheduler;
    localparam int SW    = 8;
    localparam int MW    = 32;
    localparam int CL    = 4;
    localparam int NF    = 3;
    localparam int MAXF  = 5;
    localparam int FRAME = CL + 1;

    logic           clk = 1'b0;
    logic           rst_n, start, abort, in_valid;
    logic [SW-1:0]  in_data;
    logic           in_ready;
    logic [MW-1:0]  threshold;
    logic           filt_rst, out_valid;
    logic [SW-1:0]  out_data;
    logic [NF-1:0]  filt_valid;
    logic [NF*MW-1:0] filt_score;
    logic           busy, result_valid;
    logic [1:0]     result_id;
    logic [MW-1:0]  result_score;
    logic           result_match, result_timeout;

    int checks = 0;
    int failures = 0;

    int            kv [NF];
    logic [MW-1:0] sv [NF];
    int            kdup;
    logic [MW-1:0] sdup;
    logic [SW-1:0] cap_data [CL];

    fingerprint_match_scheduler #(
        .SAMPLE_DATA_WIDTH(SW), .MATCH_SCORE_WIDTH(MW), .CAPTURE_LENGTH(CL),
        .NUM_FILTERS(NF), .MAX_FRAMES(MAXF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .threshold(threshold), .filt_rst(filt_rst),
        .out_valid(out_valid), .out_data(out_data),
        .filt_valid(filt_valid), .filt_score(filt_score),
        .busy(busy), .result_valid(result_valid), .result_id(result_id),
        .result_score(result_score), .result_match(result_match),
        .result_timeout(result_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_filt_rst"}, filt_rst, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_result_valid"}, result_valid, 1'b0);
        check({tag, "_result_id"}, result_id, '0);
        check({tag, "_result_score"}, result_score, '0);
        check({tag, "_result_match"}, result_match, 1'b0);
        check({tag, "_result_timeout"}, result_timeout, 1'b0);
    endtask

    // One full start/capture/replay/decide pass; strobe cycles come from kv/sv/kdup.
    task automatic run_case(input logic [MW-1:0] thr, input int kabort, input int kreset,
                            input logic cap_strobe, input logic [1:0] exp_id,
                            input logic [MW-1:0] exp_score, input logic exp_match,
                            input logic exp_to);
        int   e, kres, c;
        logic all_strobe, exp_v;
        e = 0;
        all_strobe = 1'b1;
        for (int i = 0; i < NF; i++) begin
            if (kv[i] == 0) all_strobe = 1'b0;
            else if (kv[i] > e) e = kv[i];
        end
        if (!all_strobe || e > MAXF*FRAME) e = MAXF*FRAME;
        kres = e + NF + 1;

        start = 1'b1; threshold = thr;
        tick();
        start = 1'b0; threshold = '0;
        check("busy_after_start", busy, 1'b1);
        check("in_ready_capture", in_ready, 1'b1);
        check("filt_rst_capture", filt_rst, 1'b1);
        if (cap_strobe) begin
            filt_valid = 3'b001;
            filt_score[0 +: MW] = 32'd50;
        end
        for (int i = 0; i < CL; i++) begin
            in_valid = 1'b1; in_data = cap_data[i];
            tick();
            in_valid = 1'b0;
            if (i < CL-1) begin
                tick();
                check("in_ready_gap", in_ready, 1'b1);
            end
        end
        filt_valid = '0;
        check("in_ready_drop", in_ready, 1'b0);

        for (int k = 1; k <= kres + 1; k++) begin
            c = k - 2;
            exp_v = (c >= 1) && (c <= e) && (((c-1) % FRAME) != CL);
            check("out_valid", out_valid, exp_v);
            if (exp_v) check("out_data", out_data, cap_data[(c-1) % FRAME]);
            check("filt_rst", filt_rst, k > e);
            check("busy", busy, k <= kres);
            check("result_valid", result_valid, k == kres);
            if (k >= kres) begin
                check("result_id", result_id, exp_id);
                check("result_score", result_score, exp_score);
                check("result_match", result_match, exp_match);
                check("result_timeout", result_timeout, exp_to);
            end
            if (k == kreset) begin
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_filt_rst", filt_rst, 1'b1);
                tick();
                rst_n = 1'b1;
                tick();
                check_reset_outputs("post_rst");
                return;
            end
            filt_valid = '0;
            for (int i = 0; i < NF; i++) begin
                if (kv[i] == k) begin
                    filt_valid[i] = 1'b1;
                    filt_score[i*MW +: MW] = sv[i];
                end
            end
            if (kdup == k) begin
                filt_valid[0] = 1'b1;
                filt_score[0 +: MW] = sdup;
            end
            if (k == kabort) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                filt_valid = '0;
                check("abort_busy", busy, 1'b0);
                check("abort_filt_rst", filt_rst, 1'b1);
                check("abort_out_valid", out_valid, 1'b0);
                for (int j = 0; j < NF + 3; j++) begin
                    tick();
                    check("abort_no_result", result_valid, 1'b0);
                    check("abort_out_idle", out_valid, 1'b0);
                end
                return;
            end
            tick();
        end
        filt_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        threshold = '0; filt_valid = '0; filt_score = '0;
        kdup = 0; sdup = '0;
        cap_data[0] = 8'd10; cap_data[1] = 8'd20; cap_data[2] = 8'd30; cap_data[3] = 8'd40;

        repeat (3) tick();
        check_reset_outputs("in_rst");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("rst_release");

        // Selection: 500/120/120 in different frames, tie goes to filter 1
        kv[0] = 2; kv[1] = 7; kv[2] = 12;
        sv[0] = 32'd500; sv[1] = 32'd120; sv[2] = 32'd120;
        run_case(32'd100, 0, 0, 1'b0, 2'd1, 32'd120, 1'b0, 1'b0);
        run_case(32'd120, 0, 0, 1'b0, 2'd1, 32'd120, 1'b1, 1'b0);

        // Capture-time strobe and a later repeat strobe from filter 0 are both ignored
        kv[0] = 2; kv[1] = 3; kv[2] = 6;
        sv[0] = 32'd900; sv[1] = 32'd1000; sv[2] = 32'd1000;
        kdup = 4; sdup = 32'd5;
        run_case(32'd900, 0, 0, 1'b1, 2'd0, 32'd900, 1'b1, 1'b0);
        kdup = 0;

        // Timeout with filter 2 strobing on the very cycle the budget expires
        kv[0] = 0; kv[1] = 0; kv[2] = 25; sv[2] = 32'd7;
        run_case(32'd10, 0, 0, 1'b0, 2'd2, 32'd7, 1'b1, 1'b1);

        // Timeout with no strobes at all
        kv[2] = 0;
        run_case(32'hFFFF_FFFF, 0, 0, 1'b0, 2'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Abort mid-replay, then a clean capture of new data
        kv[0] = 2;
        run_case(32'd0, 5, 0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        cap_data[0] = 8'd1; cap_data[1] = 8'd2; cap_data[2] = 8'd3; cap_data[3] = 8'd4;
        kv[0] = 1; kv[1] = 1; kv[2] = 1;
        sv[0] = 32'd30; sv[1] = 32'd20; sv[2] = 32'd20;
        run_case(32'd25, 0, 0, 1'b0, 2'd1, 32'd20, 1'b1, 1'b0);

        // Asynchronous reset while the stream is running
        kv[0] = 0; kv[1] = 0; kv[2] = 0;
        run_case(32'd0, 0, 4, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
